decode_stage: RTL and testbench

Registered ID stage for the RISC-V core. It takes a fetched instruction and PC from IF over a valid/ready handshake and extracts all fields. It selects the immediate format from the opcode itself and generates the sign-extended immediate, so no external imm_sel is needed. Results sit in an ID/EX-facing output register, with a one-entry skid buffer so backpressure from EX never drops an instruction.

---
 rtl/decode_stage.sv | 200 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RISC-V ID stage: field extraction, opcode-driven immediate generation, one-entry skid buffer.
// Optional macro DECODE_ILLEGAL_EN enables the registered illegal-encoding flag.
module decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    imm,
  output logic [2:0]         imm_fmt,
  output logic               rd_wen,
  output logic               rs1_used,
  output logic               rs2_used,
  output logic               illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    imm;
    fmt_e               fmt;
    logic               rd_wen;
    logic               rs1_used;
    logic               rs2_used;
    logic               illegal;
  } dec_t;

  fmt_e fmt_c;
  logic ill_c;
  logic in_fire_c;
  dec_t dec_c;
  dec_t out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;

  // Immediate format is implied by the opcode; unknown opcodes fall back to R (imm = 0).
  always_comb begin
    fmt_c = FMT_R;
    case (in_inst[6:0])
      OPC_LUI, OPC_AUIPC:                                     fmt_c = FMT_U;
      OPC_JAL:                                                fmt_c = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_OP_IMM32: fmt_c = FMT_I;
      OPC_STORE:                                              fmt_c = FMT_S;
      OPC_BRANCH:                                             fmt_c = FMT_B;
      default:                                                fmt_c = FMT_R;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  always_comb begin
    ill_c = 1'b0;
    case (in_inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM,
      OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP32: ill_c = 1'b0;
      default:                                               ill_c = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) ill_c = 1'b1;
    if (in_inst[6:0] == OPC_OP && in_inst[31:25] != 7'b0000000 && in_inst[31:25] != 7'b0100000)
      ill_c = 1'b1;
    if ((in_inst[6:0] == OPC_OP32 || in_inst[6:0] == OPC_OP_IMM32) && XLEN == 32)
      ill_c = 1'b1;
  end
`else
  assign ill_c = 1'b0;
`endif

  // Field extraction and sign-extended immediate for the incoming word.
  always_comb begin
    dec_c          = '0;
    dec_c.pc       = in_pc;
    dec_c.opcode   = in_inst[6:0];
    dec_c.rd       = in_inst[11:7];
    dec_c.funct3   = in_inst[14:12];
    dec_c.rs1      = in_inst[19:15];
    dec_c.rs2      = in_inst[24:20];
    dec_c.funct7   = in_inst[31:25];
    dec_c.shamt    = in_inst[20 +: SHAMT_W];
    dec_c.fmt      = fmt_c;
    case (fmt_c)
      FMT_I:   dec_c.imm = XLEN'($signed(in_inst[31:20]));
      FMT_S:   dec_c.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B:   dec_c.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      FMT_U:   dec_c.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_J:   dec_c.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      default: dec_c.imm = '0;
    endcase
    dec_c.rd_wen   = (fmt_c != FMT_S) && (fmt_c != FMT_B) && (in_inst[11:7] != 5'd0) && !ill_c;
    dec_c.rs1_used = (fmt_c != FMT_U) && (fmt_c != FMT_J);
    dec_c.rs2_used = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
    dec_c.illegal  = ill_c;
  end

  assign in_fire_c = in_valid && in_ready_q;

  // Output register plus skid entry; flush overrides every other event.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire_c) begin
        out_d       = dec_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign shamt     = out_q.shamt;
  assign imm       = out_q.imm;
  assign imm_fmt   = out_q.fmt;
  assign rd_wen    = out_q.rd_wen;
  assign rs1_used  = out_q.rs1_used;
  assign rs2_used  = out_q.rs2_used;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 and an RV64 instance share one stimulus stream.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready_a, out_valid_a, rd_wen_a, rs1_used_a, rs2_used_a, illegal_a;
  logic [31:0] out_pc_a, imm_a;
  logic [6:0]  opcode_a, funct7_a;
  logic [4:0]  rd_a, rs1_a, rs2_a, shamt_a;
  logic [2:0]  funct3_a, imm_fmt_a;

  logic        in_ready_b, out_valid_b, rd_wen_b, rs1_used_b, rs2_used_b, illegal_b;
  logic [31:0] out_pc_b;
  logic [63:0] imm_b;
  logic [6:0]  opcode_b, funct7_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [5:0]  shamt_b;
  logic [2:0]  funct3_b, imm_fmt_b;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  decode_stage #(.XLEN(32), .PC_W(32), .SHAMT_W(5)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .opcode(opcode_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a),
    .funct3(funct3_a), .funct7(funct7_a), .shamt(shamt_a), .imm(imm_a), .imm_fmt(imm_fmt_a),
    .rd_wen(rd_wen_a), .rs1_used(rs1_used_a), .rs2_used(rs2_used_a), .illegal(illegal_a)
  );

  decode_stage #(.XLEN(64), .PC_W(32), .SHAMT_W(6)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .opcode(opcode_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
    .funct3(funct3_b), .funct7(funct7_b), .shamt(shamt_b), .imm(imm_b), .imm_fmt(imm_fmt_b),
    .rd_wen(rd_wen_b), .rs1_used(rs1_used_b), .rs2_used(rs2_used_b), .illegal(illegal_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh5;
    logic [5:0]  sh6;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        wen, u1, u2, ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] idx;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] pc = 32'h0000_1000;

  // Hand-decoded vectors; wen is the value with no illegal override, ill the value when checking is on.
  function automatic vec_t golden(input int i);
    vec_t v;
    case (i)
      0: v = '{32'hFFF10093, 7'h13, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 5'd31, 6'd63,
               32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      1: v = '{32'hFE208EE3, 7'h63, 5'd29, 5'd1, 5'd2, 3'd0, 7'h7F, 5'd2, 6'd34,
               32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0};
      2: v = '{32'h123452B7, 7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 5'd3, 6'd35,
               32'h12345000, 64'h00000000_12345000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
      3: v = '{32'h02109093, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'h01, 5'd1, 6'd33,
               32'h00000021, 64'h00000000_00000021, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      4: v = '{32'h00000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 6'd0,
               32'h00000000, 64'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1};
      5: v = '{32'h002081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 5'd2, 6'd2,
               32'h00000000, 64'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      6: v = '{32'h0020A423, 7'h23, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 5'd2, 6'd2,
               32'h00000008, 64'h00000000_00000008, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
      7: v = '{32'hFF9FF0EF, 7'h6F, 5'd1, 5'd31, 5'd25, 3'd7, 7'h7F, 5'd25, 6'd57,
               32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
      default: v = '{32'h022081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 5'd2, 6'd34,
               32'h00000000, 64'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer pops the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid_a && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=pc %h required=no output", out_pc_a);
        end else begin
          item_t it;
          vec_t  v;
          logic  ill;
          it  = sb.pop_front();
          v   = golden(int'(it.idx));
          ill = ILL_EN & v.ill;
          chk("txn32",
              160'({out_pc_a, opcode_a, rd_a, rs1_a, rs2_a, funct3_a, funct7_a, shamt_a, imm_a,
                    imm_fmt_a, rd_wen_a, rs1_used_a, rs2_used_a, illegal_a}),
              160'({it.pc, v.op, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.sh5, v.imm32,
                    v.fmt, v.wen & ~ill, v.u1, v.u2, ill}));
          chk("txn64",
              160'({out_pc_b, opcode_b, rd_b, rs1_b, rs2_b, funct3_b, funct7_b, shamt_b, imm_b,
                    imm_fmt_b, rd_wen_b, rs1_used_b, rs2_used_b, illegal_b, out_valid_b}),
              160'({it.pc, v.op, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.sh6, v.imm64,
                    v.fmt, v.wen & ~ill, v.u1, v.u2, ill, 1'b1}));
        end
      end
    end
  end

  // Present a vector until accepted; leaves in_valid high so transfers can run back-to-back.
  task automatic send(input int idx);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_inst  = golden(idx).inst;
    in_pc    = pc;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready_a && !flush) begin
        sb.push_back('{pc, 32'(idx)});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not accepted required=accepted idx=%0d", idx);
    end
    pc = pc + 32'd4;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", 160'(sb.size()), 160'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 160'({out_valid_a, out_valid_b, opcode_a, out_pc_a, imm_a, imm_b}), 160'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 160'({in_ready_a, in_ready_b, out_valid_a}), 160'(3'b110));

    // Single instruction: out_valid one cycle after the input transfer.
    @(posedge clk); #1;
    send(0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency", 160'({out_valid_a, out_valid_b}), 160'(2'b11));

    // Streaming through all formats with no backpressure.
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) send(i);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: A held, B in skid, C refused until EX drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1);
    send(2);
    in_valid = 1'b1;
    in_inst  = golden(3).inst;
    in_pc    = pc;
    @(negedge clk);
    chk("stall_ready", 160'({in_ready_a, in_ready_b, out_valid_a, out_pc_a}), 160'({3'b001, pc - 32'd8}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold", 160'({in_ready_a, out_valid_a, out_pc_a}), 160'({2'b01, pc - 32'd8}));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3);
    in_valid = 1'b0;
    wait_drain();

    // Flush with both entries full and a pending input: everything discarded.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4);
    send(5);
    in_valid = 1'b1;
    in_inst  = golden(6).inst;
    in_pc    = pc;
    pc       = pc + 32'd4;
    flush    = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_clear", 160'({out_valid_a, out_valid_b, in_ready_a, in_ready_b}), 160'(4'b0011));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_latency", 160'({out_valid_a, out_valid_b, out_pc_a}), 160'({2'b11, pc - 32'd4}));
    wait_drain();

    // Asynchronous reset while stalled clears both entries immediately.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8);
    send(0);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("reset_mid_stall", 160'({out_valid_a, out_valid_b}), 160'(2'b00));
    sb.delete();
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_reset2", 160'({in_ready_a, in_ready_b, out_valid_a}), 160'(3'b110));
    @(posedge clk); #1;
    send(3);
    send(8);
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
